// File: rtl/serdes_pkg.sv
// Shared types and the bit-order helper for the framed SERDES.
package serdes_pkg;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    // Maps transmission order k to the data bit carried at that position.
    function automatic int bit_index(input int k, input int msb_first, input int w);
        if (msb_first != 0) begin
            return w - 1 - k;
        end else begin
            return k;
        end
    endfunction

endpackage

// File: rtl/serdes_rx_core.sv
// RX half: assembles a valid-qualified serial stream into a parallel word,
// writing each bit at its indexed position and flagging early/full/abort events.
module serdes_rx_core
    import serdes_pkg::*;
#(
    parameter int SERDES_WIDTH = 16,
    parameter int EARLY_WIDTH  = 4,
    parameter int MSB_FIRST    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    serial_in,
    input  logic                    serial_in_valid,
    input  logic                    rx_start,
    output logic [SERDES_WIDTH-1:0] parallel_out,
    output logic                    early_rdy,
    output logic                    parallel_rdy,
    output logic                    rx_abort
);

    localparam int CW  = $clog2(SERDES_WIDTH);
    localparam int RCW = CW + 1;
    localparam logic [CW-1:0]  FIRST_IDX = CW'(bit_index(0, MSB_FIRST, SERDES_WIDTH));
    localparam logic [RCW-1:0] ONE_CNT   = RCW'(1);
    localparam logic [RCW-1:0] EARLY_CNT = RCW'(EARLY_WIDTH);
    localparam logic [RCW-1:0] FULL_CNT  = RCW'(SERDES_WIDTH);

    rx_state_t                rx_state_q, rx_state_d;
    logic [RCW-1:0]           rx_cnt_q, rx_cnt_d, rx_cnt_inc_s;
    logic [CW-1:0]            wr_idx_s;
    logic [SERDES_WIDTH-1:0]  par_q, par_d;
    logic                     early_q, early_d;
    logic                     rdy_q, rdy_d;
    logic                     abort_q, abort_d;

    assign rx_cnt_inc_s = rx_cnt_q + ONE_CNT;
    assign wr_idx_s     = CW'(bit_index(int'(rx_cnt_q), MSB_FIRST, SERDES_WIDTH));

    // A valid start always wins, even over the bit that would complete a word.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        par_d      = par_q;
        early_d    = 1'b0;
        rdy_d      = 1'b0;
        abort_d    = 1'b0;
        if (serial_in_valid && rx_start) begin
            par_d            = {SERDES_WIDTH{1'b0}};
            par_d[FIRST_IDX] = serial_in;
            rx_cnt_d         = ONE_CNT;
            rx_state_d       = RX_SHIFT;
            abort_d          = (rx_state_q == RX_SHIFT);
            early_d          = (ONE_CNT == EARLY_CNT);
        end else if (serial_in_valid && (rx_state_q == RX_SHIFT)) begin
            par_d[wr_idx_s] = serial_in;
            rx_cnt_d        = rx_cnt_inc_s;
            early_d         = (rx_cnt_inc_s == EARLY_CNT);
            if (rx_cnt_inc_s == FULL_CNT) begin
                rdy_d      = 1'b1;
                rx_state_d = RX_IDLE;
            end else begin
                rdy_d      = 1'b0;
            end
        end else begin
            rx_state_d = rx_state_q;
        end
    end

    // RX state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= {RCW{1'b0}};
            par_q      <= {SERDES_WIDTH{1'b0}};
            early_q    <= 1'b0;
            rdy_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            par_q      <= par_d;
            early_q    <= early_d;
            rdy_q      <= rdy_d;
            abort_q    <= abort_d;
        end
    end

    assign parallel_out = par_q;
    assign early_rdy    = early_q;
    assign parallel_rdy = rdy_q;
    assign rx_abort     = abort_q;

endmodule

// File: rtl/serdes_framed.sv
// Framed SERDES: TX serialiser with zero-gap streaming, plus an independent
// RX assembler on the same clock.
module serdes_framed
    import serdes_pkg::*;
#(
    parameter int SERDES_WIDTH = 16,
    parameter int EARLY_WIDTH  = 4,
    parameter int MSB_FIRST    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SERDES_WIDTH-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    serial_out,
    output logic                    serial_frame,
    output logic                    serial_done,
    input  logic                    serial_in,
    input  logic                    serial_in_valid,
    input  logic                    rx_start,
    output logic [SERDES_WIDTH-1:0] parallel_out,
    output logic                    early_rdy,
    output logic                    parallel_rdy,
    output logic                    rx_abort
);

    localparam int CW = $clog2(SERDES_WIDTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SERDES_WIDTH - 1);
    localparam logic [CW-1:0] FIRST_IDX = CW'(bit_index(0, MSB_FIRST, SERDES_WIDTH));

    tx_state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]           tx_cnt_q, tx_cnt_d, tx_cnt_inc_s;
    logic [CW-1:0]           next_idx_s;
    logic [SERDES_WIDTH-1:0] hold_q, hold_d;
    logic                    ser_q, ser_d;
    logic                    frame_q, frame_d;
    logic                    done_q, done_d;
    logic                    last_s, accept_s;

    assign last_s       = (tx_state_q == TX_SHIFT) && (tx_cnt_q == CNT_LAST);
    assign tx_ready     = !rst && ((tx_state_q == TX_IDLE) || last_s);
    assign accept_s     = tx_valid && tx_ready;
    assign tx_cnt_inc_s = tx_cnt_q + CW'(1);
    assign next_idx_s   = CW'(bit_index(int'(tx_cnt_inc_s), MSB_FIRST, SERDES_WIDTH));

    // Accepting on the last bit loads the next word directly, so streams have no gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        hold_d     = hold_q;
        ser_d      = ser_q;
        frame_d    = 1'b0;
        done_d     = 1'b0;
        if (accept_s) begin
            hold_d     = tx_data;
            tx_cnt_d   = {CW{1'b0}};
            tx_state_d = TX_SHIFT;
            ser_d      = tx_data[FIRST_IDX];
            frame_d    = 1'b1;
        end else if (tx_state_q == TX_SHIFT) begin
            if (last_s) begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = {CW{1'b0}};
                ser_d      = 1'b0;
            end else begin
                tx_cnt_d   = tx_cnt_inc_s;
                ser_d      = hold_q[next_idx_s];
                done_d     = (tx_cnt_inc_s == CNT_LAST);
            end
        end else begin
            ser_d = 1'b0;
        end
    end

    // TX state and serial output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= {CW{1'b0}};
            hold_q     <= {SERDES_WIDTH{1'b0}};
            ser_q      <= 1'b0;
            frame_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            hold_q     <= hold_d;
            ser_q      <= ser_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
        end
    end

    assign serial_out   = ser_q;
    assign serial_frame = frame_q;
    assign serial_done  = done_q;

    serdes_rx_core #(
        .SERDES_WIDTH (SERDES_WIDTH),
        .EARLY_WIDTH  (EARLY_WIDTH),
        .MSB_FIRST    (MSB_FIRST)
    ) u_rx (
        .clk             (clk),
        .rst             (rst),
        .serial_in       (serial_in),
        .serial_in_valid (serial_in_valid),
        .rx_start        (rx_start),
        .parallel_out    (parallel_out),
        .early_rdy       (early_rdy),
        .parallel_rdy    (parallel_rdy),
        .rx_abort        (rx_abort)
    );

endmodule

// File: doc/serdes_framed.md
Name: serdes_framed

Overview:
- Parametrised successor to the team's fixed-format SERDES. It has two independent halves on one clock.
- TX half: a parallel word enters through a valid/ready handshake. The word is shifted out serially with a frame strobe, and back-to-back words stream with no gap.
- RX half: a valid-qualified serial stream with an explicit frame-start strobe is assembled into a parallel word. An early-ready pulse fires after EARLY_WIDTH bits.
- Sits between the packet framing logic and the pin-level I/O.

Parameters:
- SERDES_WIDTH, 16, word width in bits (>= 2).
- EARLY_WIDTH, 4, RX bit count at which early_rdy pulses (1 .. SERDES_WIDTH-1).
- MSB_FIRST, 0, bit order for both halves: 0 = bit 0 first, 1 = bit SERDES_WIDTH-1 first.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- tx_data  in  SERDES_WIDTH  word to serialise
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX can accept a word this cycle
- serial_out  out  1  serial data, registered
- serial_frame  out  1  high while serial_out carries bit 0 of a word
- serial_done  out  1  high while serial_out carries the last bit of a word
- serial_in  in  1  serial data
- serial_in_valid  in  1  serial_in is a bit this cycle
- rx_start  in  1  frame start, coincident with the first bit
- parallel_out  out  SERDES_WIDTH  assembled word, registered
- early_rdy  out  1  one-cycle pulse: first EARLY_WIDTH bits valid in parallel_out
- parallel_rdy  out  1  one-cycle pulse: full word valid
- rx_abort  out  1  one-cycle pulse: frame restarted before completion

Behaviour:
- Reset (async, rst=1): every register is cleared and both FSMs enter IDLE.
  - Output values in reset: serial_out=0, serial_frame=0, serial_done=0, parallel_out=0, early_rdy=0, parallel_rdy=0, rx_abort=0.
  - tx_ready is combinational: 1 in TX_IDLE (the reset state), 0 while rst is asserted. It recovers on the first clock after deassertion.
  - Reset mid-word discards the word silently, with no done/abort pulse.
- Bit index k (0..W-1) is transmission order. Data bit = k if MSB_FIRST=0, else W-1-k.
- TX FSM, states TX_IDLE and TX_SHIFT; holding register plus tx_cnt of width $clog2(W).
  - tx_ready = (state==TX_IDLE) | (state==TX_SHIFT & tx_cnt==W-1).
  - Accept = tx_valid & tx_ready at an edge. At that edge the word is latched, serial_out takes bit index 0, serial_frame=1, tx_cnt=0, state=TX_SHIFT. First bit latency is 1 edge from accept.
  - In TX_SHIFT, each edge does tx_cnt+1 and drives the next bit.
  - serial_done=1 while tx_cnt==W-1.
  - At tx_cnt==W-1 with accept: the next word's bit 0 follows immediately (zero-gap streaming).
  - At tx_cnt==W-1 without accept: state goes to TX_IDLE, and serial_out, serial_frame and serial_done go to 0.
  - tx_data is ignored when not accepted.
  - No mid-word abort on the TX side.
- RX FSM, states RX_IDLE and RX_SHIFT; rx_cnt of width $clog2(W)+1. Bits are written by index, not shifted.
  - Bits arriving with serial_in_valid=0 are ignored. rx_start with serial_in_valid=0 is ignored.
  - serial_in_valid & rx_start (any state):
    - parallel_out cleared, then data bit of index 0 = serial_in.
    - rx_cnt=1, state=RX_SHIFT.
    - If the prior state was RX_SHIFT, rx_abort pulses next cycle.
  - RX_SHIFT & serial_in_valid & !rx_start: write bit index rx_cnt, then rx_cnt+1.
  - When rx_cnt becomes EARLY_WIDTH, early_rdy=1 for exactly one cycle, coincident with parallel_out holding those bits.
  - When rx_cnt becomes W:
    - parallel_rdy=1 for one cycle and state=RX_IDLE.
    - parallel_out holds until the next valid rx_start.
  - RX_IDLE & serial_in_valid & !rx_start: bit dropped, no output change.
  - With W=2 and EARLY_WIDTH=1, early_rdy pulses on the edge after the start bit. It never coincides with parallel_rdy.
  - rx_start on the same cycle as the would-be final bit takes precedence: rx_abort pulses, parallel_rdy does not.
- TX and RX are fully independent. Loopback (serial_out to serial_in, serial_frame to rx_start, serial_in_valid=1) is legal.

Decomposition:
- Package serdes_pkg holds:
  - tx_state_t {TX_IDLE, TX_SHIFT} and rx_state_t {RX_IDLE, RX_SHIFT};
  - a function bit_index(k, MSB_FIRST, W) returning the data bit index.
- One sub-module, serdes_rx_core: the RX FSM, counter and index writer. The TX logic stays in the top module.

Test Plan:
- W=16, MSB_FIRST=0: single word 0xA5C3 accepted at cycle 0 -> serial_out emits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on cycles 1..16; serial_frame high on cycle 1; serial_done high on cycle 16; tx_ready=0 on cycles 1..15.
- Back-to-back 0x0001 then 0x8000 with tx_valid held -> 32 contiguous bits, serial_frame on cycles 1 and 17, no idle cycle between words.
- Loopback, MSB_FIRST=1, word 0x1234 -> early_rdy pulses after 4 bits with parallel_out=0x1000; parallel_rdy pulses with parallel_out=0x1234.
- RX: rx_start, 7 bits, serial_in_valid low 3 cycles, rx_start again, 16 bits of 0xFFFF -> rx_abort one pulse; single parallel_rdy with 0xFFFF; gaps add no bits.
- rst pulsed during TX bit 5 and RX bit 9 -> all outputs 0 immediately; tx_ready=1 on the first clock after release; no done, rdy or abort pulses.
- W=2, EARLY_WIDTH=1 loopback 0b10 -> early_rdy then parallel_rdy on consecutive cycles, parallel_out=0b10.
